// File: rtl/lab2_proc_mem_arb_pkg.sv
// Shared types for the processor/memory arbiter.
// Round-robin grant is enabled by defining LAB2_PROC_MEM_ARBITER_RR_EN.
package lab2_proc_mem_arb_pkg;

  typedef enum logic {
    SRC_IMEM = 1'b0,
    SRC_DMEM = 1'b1
  } src_t;

  localparam int MEM_ARB_DEFAULT_DEPTH = 4;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

endpackage

// File: rtl/lab2_proc_mem_arb_tag_fifo.sv
// One-bit source-tag FIFO tracking which port owns each in-flight request.
// Depth must be a power of two so the pointers wrap naturally.
module lab2_proc_mem_arb_tag_fifo #(
  parameter int depth = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enq,
  input  logic                   enq_tag,
  input  logic                   deq,
  output logic                   deq_tag,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(depth):0] count
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  logic [depth-1:0] mem_q, mem_d;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (enq) begin
      mem_d[wptr_q] = enq_tag;
      wptr_d        = wptr_q + 1'b1;
    end
    if (deq) rptr_d = rptr_q + 1'b1;
    if (enq && !deq)      count_d = count_q + 1'b1;
    else if (deq && !enq) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign deq_tag = mem_q[rptr_q];
  assign full    = (count_q == CW'(depth));
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/lab2_proc_mem_arbiter.sv
// Merges imem/dmem request streams onto one in-order memory port.
// LAB2_PROC_MEM_ARBITER_RR_EN selects round-robin instead of dmem priority.
module lab2_proc_mem_arbiter
  import lab2_proc_mem_arb_pkg::*;
#(
  parameter int p_max_outstanding = MEM_ARB_DEFAULT_DEPTH
) (
  input  logic         clk,
  input  logic         reset,

  input  mem_req_4B_t  imemreq_msg,
  input  logic         imemreq_val,
  output logic         imemreq_rdy,

  output mem_resp_4B_t imemresp_msg,
  output logic         imemresp_val,
  input  logic         imemresp_rdy,

  input  mem_req_4B_t  dmemreq_msg,
  input  logic         dmemreq_val,
  output logic         dmemreq_rdy,

  output mem_resp_4B_t dmemresp_msg,
  output logic         dmemresp_val,
  input  logic         dmemresp_rdy,

  output mem_req_4B_t  memreq_msg,
  output logic         memreq_val,
  input  logic         memreq_rdy,

  input  mem_resp_4B_t memresp_msg,
  input  logic         memresp_val,
  output logic         memresp_rdy,

  output logic [$clog2(p_max_outstanding):0] num_outstanding
);

  logic full, empty, enq, deq, deq_tag;
  logic src_val;
  src_t grant, head;
  logic lock_q, lock_d;
  src_t lock_src_q, lock_src_d;

`ifdef LAB2_PROC_MEM_ARBITER_RR_EN
  src_t last_grant_q, last_grant_d;
`endif

  always_comb begin
    grant = SRC_IMEM;
    if (lock_q)
      grant = lock_src_q;
    else if (imemreq_val && dmemreq_val)
`ifdef LAB2_PROC_MEM_ARBITER_RR_EN
      grant = (last_grant_q == SRC_IMEM) ? SRC_DMEM : SRC_IMEM;
`else
      grant = SRC_DMEM;
`endif
    else if (dmemreq_val)
      grant = SRC_DMEM;
  end

  assign memreq_msg = (grant == SRC_DMEM) ? dmemreq_msg : imemreq_msg;
  assign src_val    = (grant == SRC_DMEM) ? dmemreq_val : imemreq_val;
  assign memreq_val = !reset && src_val && !full;

  // Full is registered, so a same-cycle dequeue never frees a request slot.
  assign imemreq_rdy = !reset && (grant == SRC_IMEM) && memreq_rdy && !full;
  assign dmemreq_rdy = !reset && (grant == SRC_DMEM) && memreq_rdy && !full;
  assign enq         = memreq_val && memreq_rdy;

  always_comb begin
    lock_d     = memreq_val && !memreq_rdy;
    lock_src_d = grant;
  end

`ifdef LAB2_PROC_MEM_ARBITER_RR_EN
  always_comb begin
    last_grant_d = last_grant_q;
    if (enq) last_grant_d = grant;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_grant_q <= SRC_DMEM;
    else       last_grant_q <= last_grant_d;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q     <= 1'b0;
      lock_src_q <= SRC_IMEM;
    end else begin
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
    end
  end

  lab2_proc_mem_arb_tag_fifo #(
    .depth (p_max_outstanding)
  ) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .enq     (enq),
    .enq_tag (grant),
    .deq     (deq),
    .deq_tag (deq_tag),
    .full    (full),
    .empty   (empty),
    .count   (num_outstanding)
  );

  assign head         = src_t'(deq_tag);
  assign imemresp_msg = memresp_msg;
  assign dmemresp_msg = memresp_msg;
  assign imemresp_val = memresp_val && !empty && (head == SRC_IMEM);
  assign dmemresp_val = memresp_val && !empty && (head == SRC_DMEM);
  assign memresp_rdy  = !empty &&
                        ((head == SRC_IMEM) ? imemresp_rdy : dmemresp_rdy);
  assign deq          = memresp_val && memresp_rdy;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && memresp_val && empty)
      $error("memresp_val with no outstanding request");
  end
`endif

endmodule

// File: doc/lab2_proc_mem_arbiter.md
LAB2_PROC_MEM_ARBITER -- requirements
Module: lab2_proc_mem_arbiter

Interface
REQ-001 The block SHALL have parameter p_max_outstanding, default 4, setting the maximum number of in-flight memory requests (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state is clocked on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have ports imemreq_msg/val/rdy: input mem_req_4B_t / input 1 / output 1, the instruction request from the processor.
REQ-005 The block SHALL have ports imemresp_msg/val/rdy: output mem_resp_4B_t / output 1 / input 1, the instruction response to the processor.
REQ-006 The block SHALL have ports dmemreq_msg/val/rdy: input mem_req_4B_t / input 1 / output 1, the data request from the processor.
REQ-007 The block SHALL have ports dmemresp_msg/val/rdy: output mem_resp_4B_t / output 1 / input 1, the data response to the processor.
REQ-008 The block SHALL have ports memreq_msg/val/rdy: output mem_req_4B_t / output 1 / input 1, the single request port to memory.
REQ-009 The block SHALL have ports memresp_msg/val/rdy: input mem_resp_4B_t / input 1 / output 1, the single response port from memory.
REQ-010 The block SHALL have port num_outstanding, output, $clog2(p_max_outstanding)+1, the count of issued requests awaiting a response.

Function
REQ-011 Memory SHALL return responses in request order, and the block SHALL route them with a source-tag FIFO (1 bit per entry: 0=imem, 1=dmem), depth p_max_outstanding.
REQ-012 Request path SHALL be combinational (zero added latency): memreq_msg = granted source's msg, forwarded unmodified, opaque included.
REQ-013 memreq_val SHALL be high iff the granted source is valid and the tag FIFO is not full.
REQ-014 The granted source's rdy SHALL equal memreq_rdy && !full; the ungranted source's rdy SHALL be 0.
REQ-015 Fire (memreq_val && memreq_rdy) SHALL enqueue the granted source tag.
REQ-016 When the FIFO is full, both request rdys SHALL be 0 even if a response dequeues in the same cycle (no resp->req combinational path).
REQ-017 Grant lock: if memreq_val && !memreq_rdy, the same source SHALL stay granted on following cycles until it fires, so memreq_msg remains stable.
REQ-018 Response path SHALL be combinational: memresp_msg drives both imemresp_msg and dmemresp_msg; only the head-tag port's val is raised; memresp_rdy = head-tag port's rdy.
REQ-019 A response fire SHALL dequeue the head tag.
REQ-020 With the FIFO empty, memresp_rdy SHALL be 0 and both resp vals 0; in simulation, memresp_val with an empty FIFO SHALL trigger a $error.
REQ-021 On a simultaneous enqueue and dequeue (FIFO not full), occupancy SHALL stay unchanged and both transfers SHALL complete.
REQ-022 FIFO read and write pointers SHALL wrap modulo p_max_outstanding; num_outstanding SHALL equal the occupancy, range 0..p_max_outstanding.

Reset
REQ-023 Reset SHALL empty the FIFO and clear the lock, giving num_outstanding=0, memreq_val=0, memresp_rdy=0, imemresp_val=dmemresp_val=0, and imemreq_rdy=dmemreq_rdy=0.
REQ-024 Reset SHALL set last_grant=dmem, so imem wins the first contested cycle.
REQ-025 Reset asserted mid-transaction SHALL discard all outstanding tags; late memory responses are the environment's responsibility.

Configuration
REQ-026 With LAB2_PROC_MEM_ARBITER_RR_EN defined, contested cycles (both vals high, no lock) SHALL grant the source not in last_grant, and last_grant SHALL update on each fire.
REQ-027 Without LAB2_PROC_MEM_ARBITER_RR_EN, dmem SHALL have fixed priority on contested cycles, and the last_grant register SHALL be absent.
REQ-028 The grant lock (REQ-017) SHALL apply in both configurations.

Structure
REQ-029 Package lab2_proc_mem_arb_pkg SHALL hold typedef enum logic {SRC_IMEM=0, SRC_DMEM=1} src_t and localparam MEM_ARB_DEFAULT_DEPTH=4.
REQ-030 The tag FIFO SHALL be sub-module lab2_proc_mem_arb_tag_fifo (parameter depth; enq/deq/full/empty/count).
REQ-031 The grant logic and lock register SHALL be in the top module.

Verification
REQ-032 Single source: imem reqs addr 0x200, 0x204 with memreq_rdy=1 and memory latency 2 -> two memreq fires in consecutive cycles; imemresp_val pulses carry the data; dmemresp_val stays 0.
REQ-033 Contention with RR_EN: both vals held high for 4 fires -> grant order imem, dmem, imem, dmem; responses are routed to the matching ports.
REQ-034 Contention without RR_EN: both vals high -> dmem is granted until dmemreq_val drops, then imem.
REQ-035 Backpressure: memreq_rdy=0 for 3 cycles while imem is granted and dmemreq_val rises -> memreq_msg holds the imem addr; imem fires first when rdy=1.
REQ-036 Full: p_max_outstanding=4, 4 fires with no responses -> num_outstanding=4 and both req rdys are 0; one response in the next cycle -> rdy stays 0 that cycle and a request is accepted the cycle after.
REQ-037 Reset pulse with 3 outstanding -> num_outstanding=0 immediately (async); the next imem request is granted first.
